sfifo_param: RTL and testbench

- Single-clock, parametrised FIFO: the next generation of the team's fixed 16×32 FIFO wrapper, generalised in width and depth.
- Adds a first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and error pulses.
- Sits between same-clock MAC/datapath stages, e.g. GMII receive staging and frame builders, where no clock crossing is needed.

---
 rtl/sfifo_param.sv | 106 ++++++++++
 tb/tb_sfifo_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_param.sv
// rtl/sfifo_param.sv - single-clock parametrised FIFO with std/fwft read modes
// SFIFO_ERR_FLAGS_EN compiles in the overflow/underflow pulse logic.
module sfifo_param #(
  parameter int    DATA_WIDTH        = 16,
  parameter int    DEPTH             = 32,
  parameter string READ_MODE         = "std",
  parameter int    PROG_FULL_THRESH  = DEPTH - 2,
  parameter int    PROG_EMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int           AW        = $clog2(DEPTH);
  localparam bit           FWFT      = (READ_MODE == "fwft");
  localparam logic [AW:0]  CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]  CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]  CNT_PF    = (AW + 1)'(PROG_FULL_THRESH);
  localparam logic [AW:0]  CNT_PE    = (AW + 1)'(PROG_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           count_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  load;
  logic                  valid_next;

  // In fwft mode the dout register is a prefetch stage fed from memory;
  // in std mode it is loaded only by an accepted read.
  always_comb begin
    wr_acc     = wr_en && !full;
    rd_acc     = FWFT ? (rd_en && valid) : (rd_en && !empty);
    load       = FWFT ? ((!valid || rd_acc) && (wr_ptr != rd_ptr)) : rd_acc;
    valid_next = FWFT ? (load || (valid && !rd_acc)) : rd_acc;
    count_next = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = data_count + CNT_ONE;
      2'b01:   count_next = data_count - CNT_ONE;
      default: count_next = data_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (load) begin
        rd_ptr <= rd_ptr + CNT_ONE;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
      data_count <= count_next;
      valid      <= valid_next;
      full       <= (count_next == CNT_FULL);
      prog_full  <= (count_next >= CNT_PF);
      prog_empty <= (count_next <= CNT_PE);
      empty      <= FWFT ? !valid_next : (count_next == '0);
    end
  end

`ifdef SFIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// tb/tb_sfifo_param.sv - directed self-checking bench for sfifo_param (std and fwft)
module tb_sfifo_param;

`ifdef SFIFO_ERR_FLAGS_EN
  localparam logic [31:0] ERR_EN = 32'd1;
`else
  localparam logic [31:0] ERR_EN = 32'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] s_din, s_dout, f_din, f_dout;
  logic        s_wr, s_rd, s_valid, s_full, s_empty, s_pf, s_pe, s_ovf, s_unf;
  logic        f_wr, f_rd, f_valid, f_full, f_empty, f_pf, f_pe, f_ovf, f_unf;
  logic [5:0]  s_count, f_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_q[$];
  logic [15:0] exp_word;

  sfifo_param #(.DATA_WIDTH(16), .DEPTH(32), .READ_MODE("std")) u_std (
    .clk(clk), .rst_n(rst_n), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
    .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
    .prog_full(s_pf), .prog_empty(s_pe), .data_count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sfifo_param #(.DATA_WIDTH(16), .DEPTH(32), .READ_MODE("fwft")) u_fwft (
    .clk(clk), .rst_n(rst_n), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .prog_full(f_pf), .prog_empty(f_pe), .data_count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_din = '0; s_wr = 1'b0; s_rd = 1'b0;
    f_din = '0; f_wr = 1'b0; f_rd = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(s_count), 0);
    chk("rst_dout",  32'(s_dout), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_full",  32'(s_full), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_pf",    32'(s_pf), 0);
    chk("rst_pe",    32'(s_pe), 1);
    chk("rst_ovf",   32'(s_ovf), 0);
    chk("rst_unf",   32'(s_unf), 0);
    rst_n = 1'b1;
    tick();

    // fill to full
    for (int i = 0; i < 32; i++) begin
      s_din = 16'(i); s_wr = 1'b1;
      tick();
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_pf",    32'(s_pf), 32'((i + 1) >= 30));
      chk("fill_full",  32'(s_full), 32'((i + 1) == 32));
      chk("fill_pe",    32'(s_pe), 32'((i + 1) <= 2));
      chk("fill_empty", 32'(s_empty), 0);
    end
    s_din = 16'h0099;
    tick();
    chk("ovf_pulse", 32'(s_ovf), ERR_EN);
    chk("ovf_count", 32'(s_count), 32);
    s_wr = 1'b0;
    tick();
    chk("ovf_clear", 32'(s_ovf), 0);

    // simultaneous at full: read wins, write rejected
    s_wr = 1'b1; s_rd = 1'b1; s_din = 16'h0077;
    tick();
    chk("full_rw_dout",  32'(s_dout), 32'h0000);
    chk("full_rw_valid", 32'(s_valid), 1);
    chk("full_rw_count", 32'(s_count), 31);
    chk("full_rw_ovf",   32'(s_ovf), ERR_EN);
    chk("full_rw_full",  32'(s_full), 0);
    s_wr = 1'b0;

    // drain remaining 31 words
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("drain_dout",  32'(s_dout), 32'(i));
      chk("drain_valid", 32'(s_valid), 1);
      chk("drain_count", 32'(s_count), 32'(31 - i));
      chk("drain_unf",   32'(s_unf), 0);
    end
    chk("drain_empty", 32'(s_empty), 1);
    tick();
    chk("unf_pulse", 32'(s_unf), ERR_EN);
    chk("unf_valid", 32'(s_valid), 0);
    chk("unf_dout_hold", 32'(s_dout), 32'h001F);
    s_rd = 1'b0;
    tick();
    chk("unf_clear", 32'(s_unf), 0);

    // simultaneous at empty: write wins, read rejected
    s_wr = 1'b1; s_rd = 1'b1; s_din = 16'h0055;
    tick();
    chk("empty_rw_count", 32'(s_count), 1);
    chk("empty_rw_unf",   32'(s_unf), ERR_EN);
    chk("empty_rw_valid", 32'(s_valid), 0);
    chk("empty_rw_empty", 32'(s_empty), 0);
    s_rd = 1'b0;
    model_q.push_back(16'h0055);
    for (int i = 0; i < 4; i++) begin
      s_din = 16'h0056 + 16'(i);
      model_q.push_back(s_din);
      tick();
    end
    chk("lvl5_count", 32'(s_count), 5);

    // steady state at count 5 across pointer wrap
    s_rd = 1'b1;
    for (int k = 0; k < 100; k++) begin
      s_din = 16'h0100 + 16'(k);
      exp_word = model_q.pop_front();
      model_q.push_back(s_din);
      tick();
      chk("ss_dout",  32'(s_dout), 32'(exp_word));
      chk("ss_count", 32'(s_count), 5);
      chk("ss_flags", 32'({s_full, s_empty, s_pf, s_pe, s_ovf, s_unf}), 0);
    end
    s_wr = 1'b0; s_rd = 1'b0;

    // build to 17 then reset asynchronously mid-burst
    s_wr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_din = 16'h0200 + 16'(i);
      tick();
    end
    chk("pre_rst_count", 32'(s_count), 17);
    s_din = 16'h0300;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(s_count), 0);
    chk("arst_empty", 32'(s_empty), 1);
    chk("arst_pe",    32'(s_pe), 1);
    chk("arst_valid", 32'(s_valid), 0);
    chk("arst_dout",  32'(s_dout), 0);
    s_wr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    s_wr = 1'b1; s_din = 16'hBEEF;
    tick();
    s_wr = 1'b0;
    chk("post_rst_count", 32'(s_count), 1);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("post_rst_dout",  32'(s_dout), 32'hBEEF);
    chk("post_rst_valid", 32'(s_valid), 1);
    chk("post_rst_empty", 32'(s_empty), 1);

    // fwft instance
    chk("f_rst_valid", 32'(f_valid), 0);
    chk("f_rst_empty", 32'(f_empty), 1);
    chk("f_rst_count", 32'(f_count), 0);
    f_wr = 1'b1; f_din = 16'hA5A5;
    tick();
    f_wr = 1'b0;
    chk("f_w_valid", 32'(f_valid), 0);
    chk("f_w_count", 32'(f_count), 1);
    tick();
    chk("f_pf_valid", 32'(f_valid), 1);
    chk("f_pf_dout",  32'(f_dout), 32'hA5A5);
    chk("f_pf_empty", 32'(f_empty), 0);
    chk("f_pf_count", 32'(f_count), 1);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("f_ack_valid", 32'(f_valid), 0);
    chk("f_ack_count", 32'(f_count), 0);

    // streaming: one word per cycle with acknowledge held
    f_wr = 1'b1; f_din = 16'h1000;
    tick();
    f_din = 16'h1001;
    tick();
    chk("f_st0_dout", 32'(f_dout), 32'h1000);
    f_rd = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      f_din = 16'h1000 + 16'(j + 1);
      tick();
      chk("f_st_dout",  32'(f_dout), 32'h1000 + 32'(j));
      chk("f_st_valid", 32'(f_valid), 1);
      chk("f_st_count", 32'(f_count), 2);
    end
    f_wr = 1'b0;
    tick();
    chk("f_dr_dout",  32'(f_dout), 32'h1015);
    chk("f_dr_count", 32'(f_count), 1);
    tick();
    chk("f_dr_valid", 32'(f_valid), 0);
    chk("f_dr_empty", 32'(f_empty), 1);
    chk("f_dr_count0", 32'(f_count), 0);
    tick();
    chk("f_unf", 32'(f_unf), ERR_EN);
    f_rd = 1'b0;
    tick();
    chk("f_unf_clear", 32'(f_unf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
